// File: rtl/chirp_detector.sv
// chirp_detector
//   Samples a 1-bit chirp, measures rising-edge spacing in clk cycles and
//   tracks runs of monotonically shrinking (up-chirp) or growing (down-chirp)
//   periods. Asserts detect once MIN_STEPS consistent comparisons are seen.
//
//   Optional feature macro: CHIRP_DET_GLITCH_FILTER_EN
//     defined   -> level accepted only after 2 equal s2 samples (3-cycle latency)
//     undefined -> edge taken straight from s2/s3 (2-cycle latency)
//
// Ports
//   clk          in   system clock
//   rst          in   asynchronous active-high reset
//   en           in   block enable; low returns the block to idle
//   sig_in       in   asynchronous chirp input
//   period_out   out  last measured period (PERIOD_W bits)
//   period_valid out  one-cycle pulse when period_out updates
//   dir          out  1 = periods decreasing, 0 = increasing
//   step_cnt     out  run length of consistent comparisons (saturates at 255)
//   detect       out  lock indicator
//   timeout      out  one-cycle pulse when the period counter saturates
module chirp_detector #(
  parameter int unsigned PERIOD_W  = 16,
  parameter int unsigned MIN_STEPS = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                sig_in,
  output logic [PERIOD_W-1:0] period_out,
  output logic                period_valid,
  output logic                dir,
  output logic [7:0]          step_cnt,
  output logic                detect,
  output logic                timeout
);

  typedef enum logic [1:0] {StIdle, StMeasure, StTrack, StLocked} state_e;

  state_e              state_q;
  logic                s1_q, s2_q, s3_q;
  logic                rise;
  logic [PERIOD_W-1:0] cnt_q, prev_q, period_q;
  logic                valid_q, dir_q, detect_q, timeout_q;
  logic [7:0]          step_q;

  // Synchronizer and history flop run regardless of en.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= sig_in;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

`ifdef CHIRP_DET_GLITCH_FILTER_EN
  logic s2f_q, s2f_d;

  // Filtered level only moves when two consecutive s2 samples agree.
  always_comb begin
    s2f_d = s2f_q;
    if (s2_q == s3_q) s2f_d = s2_q;
  end

  assign rise = s2f_d & ~s2f_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) s2f_q <= 1'b0;
    else     s2f_q <= s2f_d;
  end
`else
  assign rise = s2_q & ~s3_q;
`endif

  logic                cnt_max;
  logic [PERIOD_W-1:0] cnt_inc;
  logic [7:0]          step_inc, step_new;
  logic                dir_new, lock_new;

  // Outcome of comparing the period just ended against the previous one.
  always_comb begin
    cnt_max  = &cnt_q;
    cnt_inc  = cnt_max ? cnt_q : cnt_q + PERIOD_W'(1);
    step_inc = (step_q == 8'hFF) ? step_q : step_q + 8'd1;
    step_new = 8'd0;
    dir_new  = dir_q;
    if (cnt_q < prev_q) begin
      step_new = (dir_q || step_q == 8'd0) ? step_inc : 8'd1;
      dir_new  = 1'b1;
    end else if (cnt_q > prev_q) begin
      step_new = (!dir_q || step_q == 8'd0) ? step_inc : 8'd1;
      dir_new  = 1'b0;
    end
    lock_new = 32'(step_new) >= MIN_STEPS;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      prev_q    <= '0;
      period_q  <= '0;
      valid_q   <= 1'b0;
      dir_q     <= 1'b0;
      step_q    <= 8'd0;
      detect_q  <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
      if (!en) begin
        state_q  <= StIdle;
        cnt_q    <= '0;
        dir_q    <= 1'b0;
        step_q   <= 8'd0;
        detect_q <= 1'b0;
      end else begin
        cnt_q <= rise ? PERIOD_W'(1) : cnt_inc;
        case (state_q)
          StIdle: begin
            if (rise) state_q <= StMeasure;
          end
          StMeasure, StTrack, StLocked: begin
            if (rise) begin
              period_q <= cnt_q;
              valid_q  <= 1'b1;
              prev_q   <= cnt_q;
              if (state_q == StMeasure) begin
                step_q  <= 8'd0;
                state_q <= StTrack;
              end else begin
                step_q   <= step_new;
                dir_q    <= dir_new;
                detect_q <= lock_new;
                state_q  <= lock_new ? StLocked : StTrack;
              end
            end else if (cnt_max) begin
              // A coincident edge takes priority; this only fires on a dead input.
              timeout_q <= 1'b1;
              state_q   <= StIdle;
              dir_q     <= 1'b0;
              step_q    <= 8'd0;
              detect_q  <= 1'b0;
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign period_out   = period_q;
  assign period_valid = valid_q;
  assign dir          = dir_q;
  assign step_cnt     = step_q;
  assign detect       = detect_q;
  assign timeout      = timeout_q;

endmodule

// File: tb/tb_chirp_detector.sv
// tb_chirp_detector
//   Drives directed and randomized chirps into chirp_detector and checks every
//   cycle against a model built from rising-edge timestamps, plus literal
//   expectations at key points.
module tb_chirp_detector;
  localparam int unsigned PW   = 8;
  localparam int unsigned MS   = 8;
  localparam int          MAXC = (1 << PW) - 1;
`ifdef CHIRP_DET_GLITCH_FILTER_EN
  localparam bit FILT = 1'b1;
`else
  localparam bit FILT = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst, en, sig_in;
  logic [PW-1:0] period_out;
  logic          period_valid, dir, detect, timeout;
  logic [7:0]    step_cnt;

  always #5 clk = ~clk;

  chirp_detector #(.PERIOD_W(PW), .MIN_STEPS(MS)) dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .sig_in       (sig_in),
    .period_out   (period_out),
    .period_valid (period_valid),
    .dir          (dir),
    .step_cnt     (step_cnt),
    .detect       (detect),
    .timeout      (timeout)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Samples of sig_in taken at each clock edge; edge n sees samples n-2, n-3.
  bit hist[$];
  bit filt_lvl;
  int cyc, last_edge, prev_p;
  bit active, have_prev;
  int m_period, m_step;
  bit m_valid, m_dir, m_detect, m_timeout;

  task automatic model_step();
    bit s2v, s3v, r, lvl;
    int p;
    if (rst) begin
      hist = '{1'b0, 1'b0, 1'b0};
      filt_lvl = 1'b0;
      cyc = 0; last_edge = 0; prev_p = 0;
      active = 1'b0; have_prev = 1'b0;
      m_period = 0; m_step = 0;
      m_valid = 1'b0; m_dir = 1'b0; m_detect = 1'b0; m_timeout = 1'b0;
    end else begin
      cyc++;
      s2v = hist[hist.size()-2];
      s3v = hist[hist.size()-3];
      if (FILT) begin
        lvl = (s2v == s3v) ? s2v : filt_lvl;
        r = lvl & ~filt_lvl;
        filt_lvl = lvl;
      end else begin
        r = s2v & ~s3v;
      end
      hist.push_back(sig_in);
      if (hist.size() > 6) void'(hist.pop_front());
      m_valid = 1'b0;
      m_timeout = 1'b0;
      if (!en) begin
        active = 1'b0; have_prev = 1'b0;
        m_dir = 1'b0; m_step = 0; m_detect = 1'b0;
      end else if (r) begin
        if (active) begin
          p = cyc - last_edge;
          m_period = p;
          m_valid = 1'b1;
          if (have_prev) begin
            if (p < prev_p) begin
              m_step = (m_dir || m_step == 0) ? m_step + 1 : 1;
              m_dir = 1'b1;
            end else if (p > prev_p) begin
              m_step = (!m_dir || m_step == 0) ? m_step + 1 : 1;
              m_dir = 1'b0;
            end else begin
              m_step = 0;
            end
            if (m_step > 255) m_step = 255;
            m_detect = (m_step >= MS);
          end else begin
            m_step = 0;
          end
          prev_p = p;
          have_prev = 1'b1;
        end
        active = 1'b1;
        last_edge = cyc;
      end else if (active && (cyc - last_edge) >= MAXC) begin
        m_timeout = 1'b1;
        active = 1'b0; have_prev = 1'b0;
        m_dir = 1'b0; m_step = 0; m_detect = 1'b0;
      end
    end
  endtask

  initial forever begin
    @(posedge clk or posedge rst);
    model_step();
  end

  // Per-cycle compare against the model, plus pulse counters for directed checks.
  int pv_seen = 0, to_seen = 0, det_seen = 0;
  initial forever begin
    @(negedge clk);
    chk("period_out",   32'(period_out),   32'(m_period));
    chk("period_valid", 32'(period_valid), 32'(m_valid));
    chk("dir",          32'(dir),          32'(m_dir));
    chk("step_cnt",     32'(step_cnt),     32'(m_step));
    chk("detect",       32'(detect),       32'(m_detect));
    chk("timeout",      32'(timeout),      32'(m_timeout));
    if (period_valid === 1'b1) pv_seen++;
    if (timeout === 1'b1) to_seen++;
    if (detect === 1'b1) det_seen++;
  end

  // ---------------- stimulus ----------------
  task automatic hold(input bit v, input int n);
    repeat (n) begin
      @(negedge clk);
      sig_in = v;
    end
  endtask

  task automatic per(input int t, input int h);
    hold(1'b1, h);
    hold(1'b0, t - h);
  endtask

  task automatic sq(input int t);
    per(t, t / 2);
  endtask

  task automatic restart();
    en = 1'b0;
    hold(1'b0, 3);
    en = 1'b1;
    hold(1'b0, 3);
  endtask

  int chirp[14] = '{40, 38, 36, 34, 32, 30, 28, 26, 24, 22, 20, 22, 24, 26};
  int pv0, to0, det0;

  initial begin
    rst = 1'b1; en = 1'b0; sig_in = 1'b0;
    repeat (4) begin
      @(negedge clk);
      sig_in = ~sig_in;
    end
    #1;
    chk("rst_period_out", 32'(period_out), 0);
    chk("rst_valid",      32'(period_valid), 0);
    chk("rst_step",       32'(step_cnt), 0);
    chk("rst_detect",     32'(detect), 0);
    chk("rst_timeout",    32'(timeout), 0);
    sig_in = 1'b0;
    en = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    hold(1'b0, 4);

    // First edge only starts the measurement.
    pv0 = pv_seen;
    sq(20);
    chk("first_edge_no_valid", 32'(pv_seen - pv0), 0);

    // Constant period.
    det0 = det_seen;
    repeat (12) sq(20);
    chk("const_valid_count", 32'(pv_seen - pv0), 12);
    chk("const_period",      32'(period_out), 20);
    chk("const_step",        32'(step_cnt), 0);
    chk("const_no_detect",   32'(det_seen - det0), 0);

    // Up-chirp to lock, then reversal.
    restart();
    for (int j = 0; j < 14; j++) begin
      sq(chirp[j]);
      if (j == 8) begin
        chk("chirp_step7",   32'(step_cnt), 7);
        chk("chirp_nolock7", 32'(detect), 0);
      end
      if (j == 9) begin
        chk("chirp_step8",  32'(step_cnt), 8);
        chk("chirp_lock",   32'(detect), 1);
        chk("chirp_dir_up", 32'(dir), 1);
        chk("chirp_period", 32'(period_out), 24);
      end
      if (j == 12) begin
        chk("rev_step",   32'(step_cnt), 1);
        chk("rev_dir",    32'(dir), 0);
        chk("rev_detect", 32'(detect), 0);
        chk("rev_period", 32'(period_out), 22);
      end
    end

    // Dead input: one timeout pulse, period_out holds.
    to0 = to_seen;
    hold(1'b0, 300);
    chk("timeout_once",   32'(to_seen - to0), 1);
    chk("timeout_detect", 32'(detect), 0);
    chk("timeout_step",   32'(step_cnt), 0);
    chk("timeout_period", 32'(period_out), 24);

    // Reset while locked.
    restart();
    for (int j = 0; j < 10; j++) sq(chirp[j]);
    chk("relock_pre", 32'(detect), 1);
    #2 rst = 1'b1;
    #1;
    chk("rst_lock_detect", 32'(detect), 0);
    chk("rst_lock_step",   32'(step_cnt), 0);
    chk("rst_lock_dir",    32'(dir), 0);
    chk("rst_lock_period", 32'(period_out), 0);
    @(negedge clk);
    #2 rst = 1'b0;
    for (int j = 0; j < 9; j++) sq(chirp[j]);
    chk("relock_not_yet", 32'(detect), 0);
    sq(chirp[9]);
    chk("relock_done", 32'(detect), 1);

    // Single-cycle glitch inside a 30-cycle period.
    restart();
    repeat (3) sq(30);
    hold(1'b1, 15); hold(1'b0, 7); hold(1'b1, 1); hold(1'b0, 7);
    sq(30);
    chk("glitch_period", 32'(period_out), FILT ? 30 : 8);

    // Minimum measurable period.
    restart();
    repeat (6) per(FILT ? 4 : 2, FILT ? 2 : 1);
    chk("min_period", 32'(period_out), FILT ? 4 : 2);

    // Randomized chirp segments.
    for (int s = 0; s < 40; s++) begin
      int t, mode, len, stp;
      t    = int'($urandom_range(20, 100));
      mode = int'($urandom_range(0, 2));
      len  = int'($urandom_range(3, 12));
      stp  = int'($urandom_range(1, 4));
      if ($urandom_range(0, 5) == 0) restart();
      for (int k = 0; k < len; k++) begin
        per(t, int'($urandom_range(2, t - 2)));
        if (mode == 1) t = t - stp;
        if (mode == 2) t = t + stp;
        if (t < 6) t = 6;
        if (t > 120) t = 120;
      end
      if ($urandom_range(0, 7) == 0) hold(1'b0, 270);
    end

    hold(1'b0, 5);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/chirp_detector.md
# chirp_detector

Receive-side counterpart to the chirp generator. Samples a 1-bit chirp (square wave) from an input pad, measures the period between successive rising edges in clock cycles, and tracks whether successive periods monotonically shrink (up-chirp) or grow (down-chirp). It asserts `detect` once a run of consistent steps is observed. It sits between the `ui_in` pad and the status/readout logic of the top level, and is used for loopback self-test of the generator.

## Interface

Parameters:
- `PERIOD_W`, 16, width of period counter and `period_out`
- `MIN_STEPS`, 8, consecutive same-direction period comparisons required for lock (1..255)

Ports:
- `clk`, input, 1, system clock; the block's only clock
- `rst`, input, 1, asynchronous, active-high reset
- `en`, input, 1, block enable; low forces synchronous return to IDLE
- `sig_in`, input, 1, asynchronous chirp input
- `period_out`, output, PERIOD_W, last measured period in clk cycles
- `period_valid`, output, 1, one-cycle pulse when `period_out` updates
- `dir`, output, 1, 1 = periods decreasing (up-chirp), 0 = increasing
- `step_cnt`, output, 8, current run length of consistent comparisons (saturates at 255)
- `detect`, output, 1, lock indicator
- `timeout`, output, 1, one-cycle pulse when the period counter saturates

## Operation

- Input path: 2-flop synchronizer (`s1`,`s2`), plus history flop `s3`; accepted rising edge = `s2 & ~s3`.
- Period counter `cnt`: loads 1 on an accepted edge, else increments, saturating at all-ones.
- States:
  - IDLE: wait for first edge → MEASURE (counter starts); no `period_valid`.
  - MEASURE: at next edge, `period_out <= cnt`, `period_valid` pulses, `prev <= cnt` → TRACK. `step_cnt` = 0.
  - TRACK: at each edge, publish period, compare `cnt` vs `prev`:
    - `cnt < prev`: if `dir`==1 or `step_cnt`==0, increment `step_cnt`; else `step_cnt <= 1`. `dir <= 1`.
    - `cnt > prev`: mirror with `dir <= 0`.
    - equal: `step_cnt <= 0`, `dir` holds.
    - `prev <= cnt`. If the new `step_cnt` ≥ MIN_STEPS → LOCKED, `detect <= 1`.
  - LOCKED: same compare rules; any step that leaves `step_cnt` < MIN_STEPS → TRACK, `detect <= 0`.
- Timeout: in MEASURE/TRACK/LOCKED, `cnt` reaching all-ones → `timeout` pulse (exactly once), → IDLE, `detect`, `step_cnt`, `dir` cleared; `period_out` holds.
- Edge and timeout in the same cycle: edge wins (counter reloads, no timeout).
- `en` low: next edge → IDLE, all outputs cleared except `period_out` (holds); synchronizer keeps running.
- Reset mid-operation: all registers to reset values immediately; the first post-reset edge counts only as an IDLE start.

## Timing

- Reset values: `period_out`=0, `period_valid`=0, `dir`=0, `step_cnt`=0, `detect`=0, `timeout`=0, state IDLE, `cnt`=0.
- Edge latency: `sig_in` high at sampling edge N → `s2` high after N+1 → `period_valid`/`period_out`/`dir`/`step_cnt`/`detect` registered at N+2 (visible the cycle after N+2). Without filter: 2 cycles.
- Period value: square wave with rising edges T cycles apart yields `period_out` = T.
- `detect` updates on the same edge as the `period_valid` that caused it.
- Minimum measurable period: 2 cycles (sig_in high 1 cycle, low 1 cycle).

## Configuration

- `CHIRP_DET_GLITCH_FILTER_EN` defined: extra stage `s2f`; a level is accepted only after 2 consecutive equal `s2` samples, and the edge is detected on the filtered level. Pulses shorter than 2 cycles are ignored. Adds 1 cycle to edge latency (3 cycles total); minimum period becomes 4.
- Undefined: edge is taken directly from `s2`/`s3`; 2-cycle latency; no glitch rejection.

## Test plan

- Reset: hold `rst` high and toggle `sig_in` → all outputs 0; release, first edge → no `period_valid`.
- Constant period 20 cycles, 12 edges → `period_valid` every 20 cycles with `period_out`=20, `step_cnt`=0, `detect` never high.
- Periods 40,38,36,…,20 (MIN_STEPS=8) → `dir`=1, `step_cnt` counts 1..8, `detect` rises with the 8th decreasing comparison; reversing to 22,24 → `step_cnt`=1, `dir`=0, `detect`=0.
- PERIOD_W=8, one edge then `sig_in` held low → `timeout` single pulse 255 cycles after the edge, state IDLE, `detect`=0.
- While locked, assert `rst` for 1 cycle → `detect`,`step_cnt`,`dir`,`period_out` = 0 immediately; relock requires a full new run.
- Single-cycle high glitch mid-period 30 → with `CHIRP_DET_GLITCH_FILTER_EN`, `period_out`=30 unchanged; without it, the period splits into two reported periods.
